// File: rtl/wave_writer.sv
// wave_writer: streams bytes into the wave main memory as little-endian 16-bit samples.
// Define WAVE_WRITER_CHECKSUM_EN to require a trailing mod-256 checksum byte per capture.
`timescale 1ns/1ps
module wave_writer #(
    parameter int SAMPLE_WIDTH = 16,
    parameter int BRAM_DEPTH   = 4096,
    parameter int WW_WIDTH     = 18
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic                    start_in,
    input  logic [WW_WIDTH-1:0]     wave_width_in,
    input  logic [7:0]              byte_in,
    input  logic                    byte_valid_in,
    output logic                    byte_ready_out,
    output logic [WW_WIDTH-1:0]     mem_addr_out,
    output logic [SAMPLE_WIDTH-1:0] mem_data_out,
    output logic                    mem_we_out,
    output logic                    busy_out,
    output logic                    done_out,
    output logic                    err_out,
    output logic [WW_WIDTH-1:0]     sample_count_out
);

    localparam logic [WW_WIDTH-1:0] DEPTH_W = WW_WIDTH'(BRAM_DEPTH);
    localparam logic [WW_WIDTH-1:0] ONE_W   = WW_WIDTH'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LO,
        S_HI,
`ifdef WAVE_WRITER_CHECKSUM_EN
        S_CHK,
`endif
        S_FIN
    } state_t;

    state_t                    state_q, state_d;
    logic [WW_WIDTH-1:0]       width_q, width_d;
    logic [WW_WIDTH-1:0]       count_q, count_d;
    logic [WW_WIDTH-1:0]       scount_q, scount_d;
    logic [WW_WIDTH-1:0]       addr_q, addr_d;
    logic [SAMPLE_WIDTH-1:0]   data_q, data_d;
    logic [7:0]                lo_q, lo_d;
    logic                      we_q, we_d;
    logic                      done_q, done_d;
`ifdef WAVE_WRITER_CHECKSUM_EN
    logic [7:0]                sum_q, sum_d;
    logic                      ok_q, ok_d;
    logic                      err_q, err_d;
`endif

    logic                      ready;
    logic                      accept;
    logic [WW_WIDTH-1:0]       width_clamped;
    logic [WW_WIDTH-1:0]       count_inc;

    always_comb begin
        ready = 1'b0;
        case (state_q)
            S_LO, S_HI: ready = 1'b1;
`ifdef WAVE_WRITER_CHECKSUM_EN
            S_CHK:      ready = 1'b1;
`endif
            default:    ready = 1'b0;
        endcase
    end

    assign accept        = byte_valid_in & ready;
    assign width_clamped = (wave_width_in > DEPTH_W) ? DEPTH_W : wave_width_in;
    assign count_inc     = count_q + ONE_W;

    // start_in has priority over everything, including a byte offered in the same cycle.
    always_comb begin
        state_d  = state_q;
        width_d  = width_q;
        count_d  = count_q;
        scount_d = scount_q;
        addr_d   = addr_q;
        data_d   = data_q;
        lo_d     = lo_q;
        we_d     = 1'b0;
        done_d   = 1'b0;
`ifdef WAVE_WRITER_CHECKSUM_EN
        sum_d    = sum_q;
        ok_d     = ok_q;
        err_d    = 1'b0;
`endif
        if (start_in) begin
            width_d  = width_clamped;
            count_d  = '0;
            scount_d = '0;
            state_d  = (width_clamped == '0) ? S_FIN : S_LO;
`ifdef WAVE_WRITER_CHECKSUM_EN
            sum_d    = 8'd0;
            ok_d     = 1'b1;
`endif
        end else begin
            case (state_q)
                S_LO: begin
                    if (accept) begin
                        lo_d    = byte_in;
                        state_d = S_HI;
`ifdef WAVE_WRITER_CHECKSUM_EN
                        sum_d   = sum_q + byte_in;
`endif
                    end
                end
                S_HI: begin
                    if (accept) begin
                        we_d     = 1'b1;
                        addr_d   = count_q;
                        data_d   = SAMPLE_WIDTH'({byte_in, lo_q});
                        count_d  = count_inc;
                        scount_d = count_inc;
`ifdef WAVE_WRITER_CHECKSUM_EN
                        sum_d    = sum_q + byte_in;
                        state_d  = (count_inc == width_q) ? S_CHK : S_LO;
`else
                        state_d  = (count_inc == width_q) ? S_FIN : S_LO;
`endif
                    end
                end
`ifdef WAVE_WRITER_CHECKSUM_EN
                S_CHK: begin
                    if (accept) begin
                        ok_d    = (byte_in == sum_q);
                        state_d = S_FIN;
                    end
                end
`endif
                S_FIN: begin
`ifdef WAVE_WRITER_CHECKSUM_EN
                    done_d  = ok_q;
                    err_d   = ~ok_q;
`else
                    done_d  = 1'b1;
`endif
                    state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q  <= S_IDLE;
            width_q  <= '0;
            count_q  <= '0;
            scount_q <= '0;
            addr_q   <= '0;
            data_q   <= '0;
            lo_q     <= 8'd0;
            we_q     <= 1'b0;
            done_q   <= 1'b0;
`ifdef WAVE_WRITER_CHECKSUM_EN
            sum_q    <= 8'd0;
            ok_q     <= 1'b1;
            err_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            width_q  <= width_d;
            count_q  <= count_d;
            scount_q <= scount_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            lo_q     <= lo_d;
            we_q     <= we_d;
            done_q   <= done_d;
`ifdef WAVE_WRITER_CHECKSUM_EN
            sum_q    <= sum_d;
            ok_q     <= ok_d;
            err_q    <= err_d;
`endif
        end
    end

    assign byte_ready_out   = ready;
    assign mem_addr_out     = addr_q;
    assign mem_data_out     = data_q;
    assign mem_we_out       = we_q;
    assign busy_out         = (state_q != S_IDLE);
    assign done_out         = done_q;
    assign sample_count_out = scount_q;
`ifdef WAVE_WRITER_CHECKSUM_EN
    assign err_out          = err_q;
`else
    assign err_out          = 1'b0;
`endif

endmodule

// File: tb/tb_wave_writer.sv
// Directed self-checking bench for wave_writer: reset, capture, zero width, clamping,
// restart, stalls and (when WAVE_WRITER_CHECKSUM_EN is defined) checksum pass/fail.
`timescale 1ns/1ps
module tb_wave_writer;

    logic        clk = 1'b0;
    logic        rst_in;
    logic        start_in;
    logic [17:0] wave_width_in;
    logic [7:0]  byte_in;
    logic        byte_valid_in;
    logic        byte_ready_out;
    logic [17:0] mem_addr_out;
    logic [15:0] mem_data_out;
    logic        mem_we_out;
    logic        busy_out;
    logic        done_out;
    logic        err_out;
    logic [17:0] sample_count_out;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    int wr_addr[$];
    int wr_data[$];
    int wr_cyc[$];
    int done_cnt = 0;
    int done_cyc = 0;
    int err_cnt = 0;

    int base_w, base_done, base_err, start_cyc;
    logic [7:0] tb_sum;

    wave_writer dut (
        .clk_in(clk), .rst_in(rst_in), .start_in(start_in),
        .wave_width_in(wave_width_in), .byte_in(byte_in),
        .byte_valid_in(byte_valid_in), .byte_ready_out(byte_ready_out),
        .mem_addr_out(mem_addr_out), .mem_data_out(mem_data_out),
        .mem_we_out(mem_we_out), .busy_out(busy_out), .done_out(done_out),
        .err_out(err_out), .sample_count_out(sample_count_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Transaction log sampled on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (mem_we_out) begin
            wr_addr.push_back(int'(mem_addr_out));
            wr_data.push_back(int'(mem_data_out));
            wr_cyc.push_back(cyc);
            $display("WRITE addr=%0d data=%04h cyc=%0d", mem_addr_out, mem_data_out, cyc);
        end
        if (done_out) begin
            done_cnt = done_cnt + 1;
            done_cyc = cyc;
            $display("DONE cyc=%0d count=%0d", cyc, sample_count_out);
        end
        if (err_out) begin
            err_cnt = err_cnt + 1;
            $display("ERR cyc=%0d", cyc);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic mark();
        base_w    = wr_addr.size();
        base_done = done_cnt;
        base_err  = err_cnt;
    endtask

    // Called and returning on a falling edge.
    task automatic do_start(input int w);
        byte_valid_in = 1'b0;
        start_in      = 1'b1;
        wave_width_in = 18'(w);
        start_cyc     = cyc;
        tb_sum        = 8'd0;
        @(negedge clk);
        start_in      = 1'b0;
        check("start_busy", {31'd0, busy_out}, 32'd1);
        if (w != 0) check("start_ready", {31'd0, byte_ready_out}, 32'd1);
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        for (int g = 0; g < gap; g++) begin
            byte_valid_in = 1'b0;
            @(negedge clk);
        end
        byte_in       = b;
        byte_valid_in = 1'b1;
        n = 0;
        while (!byte_ready_out && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) check("ready_timeout", 32'(n), 32'd0);
        tb_sum = tb_sum + b;
        @(negedge clk);
    endtask

    task automatic send_chk();
`ifdef WAVE_WRITER_CHECKSUM_EN
        send_byte(tb_sum, 0);
`endif
        byte_valid_in = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        byte_valid_in = 1'b0;
        n = 0;
        while (busy_out && n < 20000) begin
            @(negedge clk);
            n++;
        end
        check("idle_timeout", {31'd0, (n >= 20000)}, 32'd0);
        @(negedge clk);
    endtask

    initial begin
        int bad;
        logic [7:0] basic [6];
        basic = '{8'h34, 8'h12, 8'h78, 8'h56, 8'hBC, 8'h9A};
        rst_in = 1'b0; start_in = 1'b0; wave_width_in = '0;
        byte_in = 8'd0; byte_valid_in = 1'b0;
        repeat (3) @(negedge clk);

        // Reset values
        check("rst_busy",  {31'd0, busy_out}, 32'd0);
        check("rst_ready", {31'd0, byte_ready_out}, 32'd0);
        check("rst_we",    {31'd0, mem_we_out}, 32'd0);
        check("rst_done",  {31'd0, done_out}, 32'd0);
        check("rst_count", 32'(sample_count_out), 32'd0);
        @(negedge clk);
        rst_in = 1'b1;
        @(negedge clk);

        // Reset asserted mid-capture, right while a write strobe is out
        do_start(3);
        send_byte(8'h34, 0);
        send_byte(8'h12, 0);
        check("mid_we", {31'd0, mem_we_out}, 32'd1);
        #1 rst_in = 1'b0;
        #1;
        check("async_busy",  {31'd0, busy_out}, 32'd0);
        check("async_ready", {31'd0, byte_ready_out}, 32'd0);
        check("async_we",    {31'd0, mem_we_out}, 32'd0);
        check("async_addr",  32'(mem_addr_out), 32'd0);
        check("async_data",  32'(mem_data_out), 32'd0);
        check("async_count", 32'(sample_count_out), 32'd0);
        @(negedge clk);
        rst_in = 1'b1;
        mark();
        byte_in = 8'hAA; byte_valid_in = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("post_rst_ready", {31'd0, byte_ready_out}, 32'd0);
        end
        byte_valid_in = 1'b0;
        check("post_rst_writes", 32'(wr_addr.size() - base_w), 32'd0);
        check("post_rst_done",   32'(done_cnt - base_done), 32'd0);

        // Basic capture, width 3, back-to-back bytes
        mark();
        do_start(3);
        for (int i = 0; i < 6; i++) send_byte(basic[i], 0);
        send_chk();
        wait_idle();
        check("basic_nwrites", 32'(wr_addr.size() - base_w), 32'd3);
        check("basic_addr0", 32'(wr_addr[base_w]),   32'd0);
        check("basic_data0", 32'(wr_data[base_w]),   32'h1234);
        check("basic_addr1", 32'(wr_addr[base_w+1]), 32'd1);
        check("basic_data1", 32'(wr_data[base_w+1]), 32'h5678);
        check("basic_addr2", 32'(wr_addr[base_w+2]), 32'd2);
        check("basic_data2", 32'(wr_data[base_w+2]), 32'h9ABC);
        check("basic_gap01", 32'(wr_cyc[base_w+1] - wr_cyc[base_w]),   32'd2);
        check("basic_gap12", 32'(wr_cyc[base_w+2] - wr_cyc[base_w+1]), 32'd2);
        check("basic_done",  32'(done_cnt - base_done), 32'd1);
`ifndef WAVE_WRITER_CHECKSUM_EN
        check("basic_done_lat", 32'(done_cyc - wr_cyc[base_w+2]), 32'd1);
`endif
        check("basic_count", 32'(sample_count_out), 32'd3);
        check("idle_ready", {31'd0, byte_ready_out}, 32'd0);

        // Zero width
        mark();
        do_start(0);
        wait_idle();
        check("zero_done",    32'(done_cnt - base_done), 32'd1);
        check("zero_latency", 32'(done_cyc - start_cyc), 32'd2);
        check("zero_writes",  32'(wr_addr.size() - base_w), 32'd0);
        check("zero_count",   32'(sample_count_out), 32'd0);

        // Width 5000 clamps to 4096
        mark();
        do_start(5000);
        for (int i = 0; i < 4096; i++) begin
            send_byte(i[7:0], 0);
            send_byte(i[15:8], 0);
        end
        send_chk();
        wait_idle();
        check("clamp_nwrites", 32'(wr_addr.size() - base_w), 32'd4096);
        check("clamp_last_addr", 32'(wr_addr[wr_addr.size()-1]), 32'd4095);
        bad = 0;
        for (int i = 0; i < 4096; i++)
            if (wr_addr[base_w+i] != i || wr_data[base_w+i] != i) bad++;
        check("clamp_data", 32'(bad), 32'd0);
        check("clamp_done",  32'(done_cnt - base_done), 32'd1);
        check("clamp_count", 32'(sample_count_out), 32'd4096);

        // Restart after 2 of 4 samples, new width 2
        mark();
        do_start(4);
        send_byte(8'h01, 0); send_byte(8'h02, 0);
        send_byte(8'h03, 0); send_byte(8'h04, 0);
        do_start(2);
        send_byte(8'h11, 0); send_byte(8'h22, 0);
        send_byte(8'h33, 0); send_byte(8'h44, 0);
        send_chk();
        wait_idle();
        check("rs_nwrites", 32'(wr_addr.size() - base_w), 32'd4);
        check("rs_addr2", 32'(wr_addr[base_w+2]), 32'd0);
        check("rs_addr3", 32'(wr_addr[base_w+3]), 32'd1);
        check("rs_data2", 32'(wr_data[base_w+2]), 32'h2211);
        check("rs_data3", 32'(wr_data[base_w+3]), 32'h4433);
        check("rs_done",  32'(done_cnt - base_done), 32'd1);
        check("rs_done_after", {31'd0, (done_cyc > wr_cyc[base_w+3])}, 32'd1);
        check("rs_count", 32'(sample_count_out), 32'd2);

        // Random stalls
        mark();
        do_start(3);
        for (int i = 0; i < 6; i++) send_byte(basic[i], int'($urandom_range(0, 3)));
        send_chk();
        wait_idle();
        check("st_nwrites", 32'(wr_addr.size() - base_w), 32'd3);
        check("st_data0", 32'(wr_data[base_w]),   32'h1234);
        check("st_data1", 32'(wr_data[base_w+1]), 32'h5678);
        check("st_data2", 32'(wr_data[base_w+2]), 32'h9ABC);
        check("st_addr2", 32'(wr_addr[base_w+2]), 32'd2);
        check("st_done",  32'(done_cnt - base_done), 32'd1);

`ifdef WAVE_WRITER_CHECKSUM_EN
        // Checksum good
        mark();
        do_start(1);
        send_byte(8'h10, 0); send_byte(8'h20, 0);
        send_byte(8'h30, 0);
        wait_idle();
        check("ck_ok_done", 32'(done_cnt - base_done), 32'd1);
        check("ck_ok_err",  32'(err_cnt - base_err), 32'd0);
        // Checksum bad
        mark();
        do_start(1);
        send_byte(8'h10, 0); send_byte(8'h20, 0);
        send_byte(8'h31, 0);
        wait_idle();
        check("ck_bad_done", 32'(done_cnt - base_done), 32'd0);
        check("ck_bad_err",  32'(err_cnt - base_err), 32'd1);
`else
        check("no_err_pulses", 32'(err_cnt), 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/wave_writer.md
# wave_writer

Streaming capture engine that fills the wave main memory from an external byte source (SD/UART front end) so the wave loader has fresh data to copy into the oscillator and debug BRAMs. It accepts bytes over a valid/ready handshake, assembles little-endian samples, writes them sequentially from address 0, then pulses `done_out`. `done_out` drives the loader's `ui_update_trig_in`, which reloads the playback BRAMs.

## Interface
- `SAMPLE_WIDTH`, 16, sample width in bits; fixed at 16 (two bytes per sample).
- `BRAM_DEPTH`, 4096, depth of the main memory in samples.
- `WW_WIDTH`, 18, width of the wave-width and address fields.

- `clk_in`  input  1  system clock.
- `rst_in`  input  1  reset; asynchronous, active-low.
- `start_in`  input  1  single-cycle pulse that begins a capture.
- `wave_width_in`  input  WW_WIDTH  number of samples to capture; latched on `start_in`.
- `byte_in`  input  8  stream data.
- `byte_valid_in`  input  1  `byte_in` is valid.
- `byte_ready_out`  output  1  block accepts a byte this cycle.
- `mem_addr_out`  output  WW_WIDTH  main-memory write address.
- `mem_data_out`  output  SAMPLE_WIDTH  main-memory write data.
- `mem_we_out`  output  1  main-memory write strobe.
- `busy_out`  output  1  capture in progress.
- `done_out`  output  1  one-cycle pulse when a capture completes successfully.
- `err_out`  output  1  one-cycle pulse on checksum failure. Held at 0 when `WAVE_WRITER_CHECKSUM_EN` is absent.
- `sample_count_out`  output  WW_WIDTH  samples written in the current or most recent capture.

## Operation
- **Byte acceptance:** a byte is accepted on any edge where `byte_valid_in & byte_ready_out`.
- **States:**
  - IDLE: `byte_ready_out` = 0.
  - LO: `byte_ready_out` = 1; an accepted byte is stored as `sample[7:0]`; go to HI.
  - HI: `byte_ready_out` = 1; an accepted byte forms `{byte, lo}` and issues a write.
  - CHK: present only when checksum support is compiled in.
  - FIN: one cycle; pulses `done_out` or `err_out`, then returns to IDLE.
- **Start:**
  - `start_in` latches `width = min(wave_width_in, BRAM_DEPTH)`, clears the count to 0 and moves to LO.
  - If the latched width is 0, the block goes straight to FIN, performs no writes and pulses `done_out`.
- **Write issue:** each accepted HI byte writes at `mem_addr_out = count`, after which the count increments.
  - If the post-increment count equals `width`, go to CHK (when enabled) or FIN.
  - Otherwise go back to LO.
- **Restart:** `start_in` in any non-IDLE state restarts the capture immediately. The partial data is abandoned, no `done_out` is issued, and the new width is latched.
- **Address arithmetic:** `count` never exceeds `width`, so addresses never wrap past `BRAM_DEPTH-1`.
- **Stalls:** `byte_valid_in` low stalls indefinitely; there is no timeout.
- **`busy_out`:** high in LO, HI, CHK and FIN.

## Timing
- **Reset values:** all outputs 0; state IDLE; count 0; width 0.
- **`start_in` to ready:** `byte_ready_out` goes high one cycle after the `start_in` edge.
- **Write strobe:** `mem_we_out` is a registered one-cycle pulse in the cycle after the HI byte is accepted, with `mem_addr_out` and `mem_data_out` valid in that same cycle. `mem_data_out` holds its value between writes.
- **Back-to-back bytes:** with `byte_valid_in` held high, one byte is accepted per cycle and one write is issued every 2 cycles.
- **Completion:** `done_out` pulses the cycle after FIN is entered.
  - Without checksum, this is one cycle after the final `mem_we_out`.
  - With checksum, it follows the cycle after the checksum byte is accepted.
- **`sample_count_out`:** updates in the same cycle as `mem_we_out`, reads `count+1`, and holds after completion until the next start.
- **Reset mid-capture:** asynchronous `rst_in` low returns the block to IDLE immediately. Any pending write is dropped, and no `done_out` or `err_out` is issued.

## Configuration
- **Macro:** `WAVE_WRITER_CHECKSUM_EN`.
- **When defined:**
  - An 8-bit running sum (mod 256) covers every accepted data byte and clears on start.
  - After the last sample the block enters CHK, with `byte_ready_out` = 1, and accepts exactly one trailing byte.
  - If that byte equals the sum, `done_out` pulses; otherwise `err_out` pulses and `done_out` does not.
  - A width of 0 skips CHK.
- **When undefined:** there is no CHK state and no adder, `err_out` is tied to 0, and the block goes to FIN directly after the last write.

## Test plan
- **Reset values:** hold `rst_in`=0 mid-stream → all outputs 0 and state IDLE; then release and confirm `byte_ready_out` stays 0 until `start_in`.
- **Basic capture:** width 3, bytes 0x34,0x12,0x78,0x56,0xBC,0x9A with valid always high → writes 0x1234@0, 0x5678@1, 0x9ABC@2 at 2-cycle spacing, then `done_out` 1 cycle after the last `mem_we_out` and `sample_count_out`=3.
- **Zero width and clamping:** width 0 → `done_out` 2 cycles after `start_in` with no `mem_we_out`; width 5000 with `BRAM_DEPTH` 4096 → exactly 4096 writes, last address 4095.
- **Restart and stalls:** `start_in` re-pulsed after 2 of 4 samples with width 2 → the new capture writes addresses 0 and 1 with no intervening `done_out`; random `byte_valid_in` gaps → data identical to the unstalled run.
- **Checksum (`WAVE_WRITER_CHECKSUM_EN`):** width 1, bytes 0x10,0x20, checksum 0x30 → `done_out`; checksum 0x31 → `err_out`=1 and `done_out`=0.
